// File: rtl/flop_bank_pkg.sv
// Shared encodings and per-channel next-state rule for the multi-mode flop bank.
package flop_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [1:0] PRI_HOLD = 2'd0;
  localparam logic [1:0] PRI_SET  = 2'd1;
  localparam logic [1:0] PRI_RST  = 2'd2;

  function automatic logic next_q(input logic [1:0] mode, input logic s, input logic r,
                                  input logic q, input logic [1:0] pri);
    logic nq;
    nq = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = (pri == PRI_SET) ? 1'b1 : ((pri == PRI_RST) ? 1'b0 : q);
          default: nq = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b10:   nq = 1'b1;
          2'b01:   nq = 1'b0;
          2'b11:   nq = ~q;
          default: nq = q;
        endcase
      end
      MODE_D:  nq = s;
      default: nq = r ? 1'b0 : (q ^ s);  // clear wins over toggle
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/flop_cell.sv
// One storage channel: next-state selection, q/qbar registers and the SR illegal-input strobe.
module flop_cell
  import flop_bank_pkg::*;
#(
  parameter logic       RESET_VAL   = 1'b0,
  parameter logic [1:0] SR_PRIORITY = PRI_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       qbar,
  output logic       q_next,
  output logic       illegal
);

  logic q_d, q_q, qbar_q;

  always_comb begin
    q_d = en ? next_q(mode, s, r, q_q, SR_PRIORITY) : q_q;
  end

  // qbar is its own register so it switches on the same edge as q
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      qbar_q <= ~RESET_VAL;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  end

  assign q       = q_q;
  assign qbar    = qbar_q;
  assign q_next  = q_d;
  assign illegal = en && (mode == MODE_SR) && s && r;

endmodule

// File: rtl/multi_mode_flop_bank.sv
// CH-channel SR/JK/D/T flop bank with sticky illegal flags, saturating error count and change pulse.
module multi_mode_flop_bank
  import flop_bank_pkg::*;
#(
  parameter int              CH          = 8,
  parameter logic [CH-1:0]   RESET_VAL   = '0,
  parameter int              SR_PRIORITY = 0,
  parameter int              ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [CH-1:0]        s,
  input  logic [CH-1:0]        r,
  input  logic                 err_clr,
  output logic [CH-1:0]        q,
  output logic [CH-1:0]        qbar,
  output logic [CH-1:0]        err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 changed
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [CH-1:0]        q_next, illegal;
  logic [CH-1:0]        err_flag_d, err_flag_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic                 changed_d, changed_q;
  logic                 illegal_any;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    flop_cell #(
      .RESET_VAL  (RESET_VAL[i]),
      .SR_PRIORITY(2'(SR_PRIORITY))
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .s      (s[i]),
      .r      (r[i]),
      .q      (q[i]),
      .qbar   (qbar[i]),
      .q_next (q_next[i]),
      .illegal(illegal[i])
    );
  end

  assign illegal_any = |illegal;

  // A clear in the same cycle as an illegal event keeps only this cycle's evidence
  always_comb begin
    err_flag_d = err_flag_q | illegal;
    err_cnt_d  = err_cnt_q;
    if (illegal_any && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    if (err_clr) begin
      err_flag_d = illegal;
      err_cnt_d  = illegal_any ? ERR_CNT_W'(1) : '0;
    end
    changed_d = |(q_next ^ q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q <= '0;
      err_cnt_q  <= '0;
      changed_q  <= 1'b0;
    end else begin
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      changed_q  <= changed_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign changed  = changed_q;

endmodule
